// File: rtl/fft_output_sequencer.sv
// Output-phase sequencer for the FFT processor: walks one N-point frame per start request,
// producing index/address, valid strobe, stage control lines and frame status pulses.
module fft_output_sequencer #(
  parameter int unsigned LOG2N       = 6,
  parameter int unsigned PREP_CYCLES = 1,
  parameter int unsigned CTRL_LEN    = 9,
  parameter bit          BITREV      = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dataind,
  input  logic             stall,
  output logic [LOG2N-1:0] counter_o,
  output logic [LOG2N-1:0] addr_o,
  output logic             datavalid,
  output logic             last,
  output logic             frame_done,
  output logic             in_ctrl_all_out,
  output logic             hold_all_out,
  output logic             busy,
  output logic             overrun
);

  localparam int unsigned      N         = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LastIdx   = LOG2N'(N - 1);
  localparam logic [LOG2N-1:0] PenultIdx = LOG2N'(N - 2);
  localparam logic [3:0]       PrepLast  = 4'(PREP_CYCLES - 1);
  localparam logic [LOG2N:0]   CtrlLen   = (LOG2N + 1)'(CTRL_LEN);

  typedef enum logic [1:0] {StIdle, StPrep, StCount} state_e;

  state_e           r_state;
  logic [LOG2N-1:0] r_counter;
  logic [3:0]       r_prep_cnt;
  logic             r_datavalid;
  logic             r_last;
  logic             r_frame_done;
  logic             r_in_ctrl;
  logic             r_hold;
  logic             r_busy;
  logic             r_overrun;

  logic [LOG2N:0]   w_cnt_inc;
  logic [LOG2N-1:0] w_addr_rev;

  assign w_cnt_inc = {1'b0, r_counter} + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_counter    <= LastIdx;
      r_prep_cnt   <= '0;
      r_datavalid  <= 1'b0;
      r_last       <= 1'b0;
      r_frame_done <= 1'b0;
      r_in_ctrl    <= 1'b0;
      r_hold       <= 1'b1;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_datavalid <= 1'b0;
          r_last      <= 1'b0;
          if (dataind) begin
            r_state    <= StPrep;
            r_counter  <= '0;
            r_prep_cnt <= '0;
            r_in_ctrl  <= 1'b1;
            r_hold     <= 1'b0;
            r_busy     <= 1'b1;
          end else begin
            r_in_ctrl <= 1'b0;
            r_hold    <= 1'b1;
            r_busy    <= 1'b0;
          end
        end

        StPrep: begin
          r_datavalid <= 1'b0;
          r_last      <= 1'b0;
          r_in_ctrl   <= 1'b1;
          r_busy      <= 1'b1;
          r_overrun   <= dataind;
          if (stall) begin
            r_hold <= 1'b1;
          end else begin
            r_hold <= 1'b0;
            if (r_prep_cnt == PrepLast) begin
              // Index 0 is always inside the control window since CTRL_LEN >= 1.
              r_state     <= StCount;
              r_counter   <= '0;
              r_datavalid <= 1'b1;
            end else begin
              r_prep_cnt <= r_prep_cnt + 4'd1;
            end
          end
        end

        StCount: begin
          if (stall) begin
            r_datavalid <= 1'b0;
            r_last      <= 1'b0;
            r_hold      <= 1'b1;
            r_overrun   <= dataind;
          end else if (r_counter == LastIdx) begin
            r_frame_done <= 1'b1;
            r_datavalid  <= 1'b0;
            r_last       <= 1'b0;
            if (dataind) begin
              // Chain straight into the next frame without an idle cycle.
              r_state    <= StPrep;
              r_counter  <= '0;
              r_prep_cnt <= '0;
              r_in_ctrl  <= 1'b1;
              r_hold     <= 1'b0;
              r_busy     <= 1'b1;
            end else begin
              r_state   <= StIdle;
              r_in_ctrl <= 1'b0;
              r_hold    <= 1'b1;
              r_busy    <= 1'b0;
            end
          end else begin
            r_counter   <= r_counter + 1'b1;
            r_datavalid <= 1'b1;
            r_last      <= (r_counter == PenultIdx);
            r_hold      <= 1'b0;
            r_in_ctrl   <= (w_cnt_inc < CtrlLen);
            r_overrun   <= dataind;
          end
        end

        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    w_addr_rev = '0;
    for (int i = 0; i < int'(LOG2N); i++) begin
      w_addr_rev[i] = r_counter[LOG2N-1-i];
    end
  end

  assign addr_o          = BITREV ? w_addr_rev : r_counter;
  assign counter_o       = r_counter;
  assign datavalid       = r_datavalid;
  assign last            = r_last;
  assign frame_done      = r_frame_done;
  assign in_ctrl_all_out = r_in_ctrl;
  assign hold_all_out    = r_hold;
  assign busy            = r_busy;
  assign overrun         = r_overrun;

endmodule

// File: tb/tb_fft_output_sequencer.sv
// Bench for fft_output_sequencer: default 64-point instance plus a small bit-reversed instance,
// with a per-sample scoreboard filled at frame start and drained on every valid output.
module tb_fft_output_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       dataind = 1'b0;
  logic       stall = 1'b0;
  logic       dataind2 = 1'b0;
  logic       stall2 = 1'b0;

  logic [5:0] counter_o, addr_o;
  logic       datavalid, last, frame_done, in_ctrl, hold, busy, overrun;
  logic [2:0] counter2, addr2;
  logic       datavalid2, last2, frame_done2, in_ctrl2, hold2, busy2, overrun2;

  int         errors = 0;
  int         checks = 0;
  int         cyc = 0;
  int         dv_a = 0;
  logic [5:0] q_a[$];
  logic [5:0] q_b[$];
  logic [2:0] rev_tbl [0:7];

  fft_output_sequencer u_dut (
    .clk             (clk),
    .rst             (rst),
    .dataind         (dataind),
    .stall           (stall),
    .counter_o       (counter_o),
    .addr_o          (addr_o),
    .datavalid       (datavalid),
    .last            (last),
    .frame_done      (frame_done),
    .in_ctrl_all_out (in_ctrl),
    .hold_all_out    (hold),
    .busy            (busy),
    .overrun         (overrun)
  );

  fft_output_sequencer #(
    .LOG2N       (3),
    .PREP_CYCLES (2),
    .CTRL_LEN    (2),
    .BITREV      (1'b1)
  ) u_dut_small (
    .clk             (clk),
    .rst             (rst),
    .dataind         (dataind2),
    .stall           (stall2),
    .counter_o       (counter2),
    .addr_o          (addr2),
    .datavalid       (datavalid2),
    .last            (last2),
    .frame_done      (frame_done2),
    .in_ctrl_all_out (in_ctrl2),
    .hold_all_out    (hold2),
    .busy            (busy2),
    .overrun         (overrun2)
  );

  always #5 clk = ~clk;

  // Advance one cycle and drain the scoreboards for any valid sample.
  task automatic tick();
    logic [5:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (datavalid) begin
      dv_a++;
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL sb_a: unexpected valid, counter=%0d", counter_o);
      end else begin
        e = q_a.pop_front();
        if ({counter_o, addr_o, last} !== {e, e, (e == 6'd63)}) begin
          errors++;
          $display("FAIL sb_a: got cnt=%0d addr=%0d last=%b, want cnt=%0d addr=%0d last=%b",
                   counter_o, addr_o, last, e, e, (e == 6'd63));
        end
      end
    end
    if (datavalid2) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL sb_b: unexpected valid, counter=%0d", counter2);
      end else begin
        e = q_b.pop_front();
        if ({counter2, addr2, last2} !== {e, (e[5:3] == 3'd7)}) begin
          errors++;
          $display("FAIL sb_b: got cnt=%0d addr=%0d last=%b, want cnt=%0d addr=%0d last=%b",
                   counter2, addr2, last2, e[5:3], e[2:0], (e[5:3] == 3'd7));
        end
      end
    end
  endtask

  task automatic push_frame_a();
    for (int i = 0; i < 64; i++) q_a.push_back(6'(i));
  endtask

  task automatic push_frame_b();
    for (int i = 0; i < 8; i++) q_b.push_back({3'(i), rev_tbl[i]});
  endtask

  task automatic wait_counter(input logic [5:0] v);
    int n = 0;
    while (!(datavalid && counter_o == v) && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL wait_counter: timeout, counter=%0d want %0d", counter_o, v);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 300) begin
      errors++;
      $display("FAIL wait_done: timeout, frame_done=%b want 1", frame_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dataind = 1'b1;
    dataind2 = 1'b1;
    repeat (3) tick();
    checks++;
    if ({counter_o, datavalid, last, frame_done, in_ctrl, hold, busy, overrun} !==
        {6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_a: cnt=%0d dv=%b last=%b fd=%b ic=%b hold=%b busy=%b ovr=%b, want 63 0 0 0 0 1 0 0",
               counter_o, datavalid, last, frame_done, in_ctrl, hold, busy, overrun);
    end
    checks++;
    if ({counter2, datavalid2, last2, frame_done2, in_ctrl2, hold2, busy2, overrun2} !==
        {3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_b: cnt=%0d dv=%b ic=%b hold=%b busy=%b, want 7 0 0 1 0",
               counter2, datavalid2, in_ctrl2, hold2, busy2);
    end
    rst = 1'b0;
    dataind = 1'b0;
    dataind2 = 1'b0;
    tick();
    checks++;
    if ({counter_o, datavalid, hold, busy} !== {6'd63, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL idle_after_reset: cnt=%0d dv=%b hold=%b busy=%b, want 63 0 1 0",
               counter_o, datavalid, hold, busy);
    end
  endtask

  task automatic test_single_frame();
    logic [5:0] got, exp;
    dv_a = 0;
    push_frame_a();
    dataind = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      tick();
      dataind = 1'b0;
      got = {datavalid, in_ctrl, hold, frame_done, busy, overrun};
      exp = {(k >= 2 && k <= 65), (k <= 10), (k == 66), (k == 66), (k <= 65), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_frame cycle %0d: {dv,ic,hold,fd,busy,ovr}=%b want %b", k, got, exp);
      end
    end
    checks++;
    if ({counter_o, hold, dv_a, q_a.size()} !== {6'd63, 1'b1, 64, 0}) begin
      errors++;
      $display("FAIL single_frame_end: cnt=%0d hold=%b valids=%0d left=%0d, want 63 1 64 0",
               counter_o, hold, dv_a, q_a.size());
    end
  endtask

  task automatic test_stall();
    int start;
    start = cyc;
    dv_a = 0;
    push_frame_a();
    dataind = 1'b1;
    tick();
    dataind = 1'b0;
    wait_counter(6'd20);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({counter_o, datavalid, hold, in_ctrl} !== {6'd20, 1'b0, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold %0d: cnt=%0d dv=%b hold=%b ic=%b, want 20 0 1 0",
                 i, counter_o, datavalid, hold, in_ctrl);
      end
    end
    stall = 1'b0;
    tick();
    checks++;
    if ({counter_o, datavalid, hold} !== {6'd21, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stall_resume: cnt=%0d dv=%b hold=%b, want 21 1 0", counter_o, datavalid, hold);
    end
    wait_done();
    checks++;
    if ((cyc - start) != 69 || dv_a != 64 || q_a.size() != 0) begin
      errors++;
      $display("FAIL stall_frame: cycles=%0d valids=%0d left=%0d, want 69 64 0",
               cyc - start, dv_a, q_a.size());
    end
  endtask

  task automatic test_back_to_back();
    push_frame_a();
    dataind = 1'b1;
    tick();
    dataind = 1'b0;
    wait_counter(6'd63);
    dataind = 1'b1;
    push_frame_a();
    dv_a = 0;
    tick();
    dataind = 1'b0;
    checks++;
    if ({counter_o, datavalid, frame_done, in_ctrl, hold, busy, overrun} !==
        {6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL chain_prep: cnt=%0d dv=%b fd=%b ic=%b hold=%b busy=%b ovr=%b, want 0 0 1 1 0 1 0",
               counter_o, datavalid, frame_done, in_ctrl, hold, busy, overrun);
    end
    tick();
    checks++;
    if ({counter_o, datavalid, frame_done} !== {6'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL chain_first: cnt=%0d dv=%b fd=%b, want 0 1 0", counter_o, datavalid, frame_done);
    end
    wait_done();
    checks++;
    if (dv_a != 64 || q_a.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL chain_frame: valids=%0d left=%0d busy=%b, want 64 0 0", dv_a, q_a.size(), busy);
    end
  endtask

  task automatic test_overrun_reset();
    int fd_seen = 0;
    push_frame_a();
    dataind = 1'b1;
    tick();
    dataind = 1'b0;
    wait_counter(6'd30);
    dataind = 1'b1;
    tick();
    dataind = 1'b0;
    checks++;
    if ({counter_o, datavalid, overrun, busy} !== {6'd31, 1'b1, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overrun_pulse: cnt=%0d dv=%b ovr=%b busy=%b, want 31 1 1 1",
               counter_o, datavalid, overrun, busy);
    end
    tick();
    checks++;
    if ({counter_o, datavalid, overrun} !== {6'd32, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL overrun_clear: cnt=%0d dv=%b ovr=%b, want 32 1 0", counter_o, datavalid, overrun);
    end
    wait_counter(6'd40);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({counter_o, datavalid, last, frame_done, in_ctrl, hold, busy, overrun} !==
        {6'd63, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL midframe_reset: cnt=%0d dv=%b fd=%b ic=%b hold=%b busy=%b, want 63 0 0 0 1 0",
               counter_o, datavalid, frame_done, in_ctrl, hold, busy);
    end
    q_a.delete();
    repeat (5) begin
      tick();
      if (frame_done) fd_seen++;
    end
    checks++;
    if (fd_seen != 0 || busy !== 1'b0 || counter_o !== 6'd63) begin
      errors++;
      $display("FAIL after_reset: frame_done pulses=%0d busy=%b cnt=%0d, want 0 0 63",
               fd_seen, busy, counter_o);
    end
  endtask

  task automatic test_small_config();
    logic [5:0] got, exp;
    push_frame_b();
    dataind2 = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick();
      dataind2 = 1'b0;
      got = {datavalid2, in_ctrl2, hold2, frame_done2, busy2, overrun2};
      exp = {(k >= 3 && k <= 10), (k <= 4), (k == 11), (k == 11), (k <= 10), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL small_cfg cycle %0d: {dv,ic,hold,fd,busy,ovr}=%b want %b", k, got, exp);
      end
    end
    checks++;
    if (q_b.size() != 0 || counter2 !== 3'd7) begin
      errors++;
      $display("FAIL small_cfg_end: left=%0d cnt=%0d, want 0 7", q_b.size(), counter2);
    end
  endtask

  initial begin
    rev_tbl[0] = 3'd0; rev_tbl[1] = 3'd4; rev_tbl[2] = 3'd2; rev_tbl[3] = 3'd6;
    rev_tbl[4] = 3'd1; rev_tbl[5] = 3'd5; rev_tbl[6] = 3'd3; rev_tbl[7] = 3'd7;
    test_reset();
    test_single_frame();
    test_stall();
    test_back_to_back();
    test_overrun_reset();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
